branch_predict_unit: RTL and testbench
======================================

// Module: branch_predict_unit
// PURPOSE
//  Parametrised dynamic branch predictor for the MIPS pipeline; takes over from the purely
//  combinational EX-stage beq/bne resolution. IF indexes a table of saturating counters by PC and
//  issues a registered prediction. EX resolves beq/bne from Branch/BranchEqual/Zero, trains the
//  table, flags mispredicts for the flush logic, and keeps branch/mispredict statistics.
// PARAMETERS
//  INDEX_BITS  6   table depth = 2**INDEX_BITS entries, index = pc[INDEX_BITS+1:2]
//  PC_WIDTH    32  width of the PC input
//  CTR_BITS    2   saturating counter width; counter MSB=1 -> predict taken
//  CTR_INIT    1   counter value loaded on reset and clear (weakly not-taken)
//  STAT_BITS   32  width of the statistics counters
// PORTS
//  clk            in   1           pipeline clock, all state on rising edge
//  rst_n          in   1           asynchronous reset, active low
//  if_valid       in   1           IF holds a real instruction (not a STALL_OPCODE bubble)
//  if_stall       in   1           IF/ID held: prediction registers keep their value
//  if_pc          in   PC_WIDTH    PC of the instruction in IF
//  pred_taken     out  1           registered prediction for the instruction now in ID
//  pred_index     out  INDEX_BITS  registered table index, carried down the pipe to EX
//  ex_branch      in   1           Branch control of the instruction in EX
//  ex_branch_eq   in   1           BranchEqual control (1 beq, 0 bne)
//  ex_zero        in   1           ALU Zero flag in EX
//  ex_pred_taken  in   1           pred_taken piped along with that branch
//  ex_index       in   INDEX_BITS  pred_index piped along with that branch
//  ex_taken       out  1           resolved outcome, combinational
//  mispredict     out  1           ex_branch & (ex_taken != ex_pred_taken), combinational
//  tbl_clear      in   1           synchronous request to re-initialise the table
//  busy           out  1           table clear in progress
//  stat_branches  out  STAT_BITS   resolved branch count
//  stat_mispred   out  STAT_BITS   mispredict count
// BEHAVIOUR
//  Reset (rst_n=0, async): every entry = CTR_INIT, pred_taken=0, pred_index=0, busy=0,
//    stats=0, FSM=IDLE.
//  Predict: on each edge with !if_stall, pred_index <= if_pc[INDEX_BITS+1:2] and
//    pred_taken <= if_valid & table[idx][CTR_BITS-1] & !busy. Latency 1 cycle (IF -> ID).
//  Resolve: ex_taken = ex_branch & (ex_branch_eq ? ex_zero : ~ex_zero). ex_taken and
//    mispredict are 0 whenever ex_branch=0.
//  Train: on an edge with ex_branch=1 and FSM=IDLE, table[ex_index] +1 if ex_taken (saturate at
//    2**CTR_BITS-1), -1 if not taken (saturate at 0). No other entry changes.
//  Same-index read and write on one edge: the prediction uses the pre-update value (no bypass).
//  if_stall does not block training. EX bubbles arrive with ex_branch=0.
//  Stats: on an edge with ex_branch=1 and FSM=IDLE, stat_branches +1. stat_mispred +1 on the same
//    condition when mispredict=1. Both saturate at all-ones and never wrap.
//  Clear FSM: IDLE --tbl_clear--> CLEAR. CLEAR writes CTR_INIT to entry clr_ptr (from 0) and
//    increments it each cycle. After writing entry 2**INDEX_BITS-1 it returns to IDLE, so CLEAR
//    lasts 2**INDEX_BITS cycles.
//  In CLEAR: busy=1, predictions are forced to 0, training and stats are dropped. tbl_clear is
//    ignored in CLEAR (no restart). Stats are not cleared by tbl_clear.
//  Reset mid-clear aborts the clear: the table is fully initialised by reset, FSM=IDLE.
// STRUCTURE
//  Shared ctrl_pkg (also used by the decoder): opcode/funct constants incl. STALL_OPCODE,
//    ALU control codes, FSM state encodings BP_IDLE/BP_CLEAR.
//  One sub-module, bp_sat_counter (CTR_BITS, CTR_INIT): a single entry with inc/dec/load.
//    Instantiate it 2**INDEX_BITS times via generate. Index decode, FSM and stats stay in the top.
// TESTING
//  1 Reset release, if_pc=0x40, if_valid=1 -> next cycle pred_taken=0, pred_index=0x10, stats=0.
//  2 Train: beq, ex_zero=1, ex_index=0x10, ex_pred_taken=0, 1 cycle -> ex_taken=1, mispredict=1.
//    Then table[0x10]=2 and pc 0x40 predicts taken. 3 more taken -> counter stays 3.
//  3 bne, ex_zero=1, ex_pred_taken=1 -> ex_taken=0, mispredict=1. 3 not-taken -> counter 0,
//    no underflow.
//  4 Same edge: train idx 5 (1->2) and if_pc=0x14 -> pred_taken=0 (old value). Next read = 1.
//  5 Pulse tbl_clear -> busy=1 for exactly 64 cycles with pred_taken=0 and training dropped.
//    Afterwards all entries = 1. Drop rst_n at cycle 20 of the clear -> busy=0 at once.
//  6 STAT_BITS=4: 20 mispredicted branches -> both stats saturate at 0xF. ex_branch=0 -> no count.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared MIPS control constants: opcodes, funct codes, ALU control codes and
// the branch predictor clear-FSM state encoding.
package ctrl_pkg;

    localparam int unsigned OPCODE_BITS = 6;
    localparam int unsigned FUNCT_BITS  = 6;
    localparam int unsigned ALUCTL_BITS = 4;

    localparam logic [OPCODE_BITS-1:0] OP_RTYPE     = 6'h00;
    localparam logic [OPCODE_BITS-1:0] OP_J         = 6'h02;
    localparam logic [OPCODE_BITS-1:0] OP_BEQ       = 6'h04;
    localparam logic [OPCODE_BITS-1:0] OP_BNE       = 6'h05;
    localparam logic [OPCODE_BITS-1:0] OP_ADDI      = 6'h08;
    localparam logic [OPCODE_BITS-1:0] OP_LW        = 6'h23;
    localparam logic [OPCODE_BITS-1:0] OP_SW        = 6'h2B;
    localparam logic [OPCODE_BITS-1:0] STALL_OPCODE = 6'h3F;

    localparam logic [FUNCT_BITS-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_BITS-1:0] FN_SUB = 6'h22;
    localparam logic [FUNCT_BITS-1:0] FN_AND = 6'h24;
    localparam logic [FUNCT_BITS-1:0] FN_OR  = 6'h25;
    localparam logic [FUNCT_BITS-1:0] FN_SLT = 6'h2A;

    localparam logic [ALUCTL_BITS-1:0] ALU_AND = 4'h0;
    localparam logic [ALUCTL_BITS-1:0] ALU_OR  = 4'h1;
    localparam logic [ALUCTL_BITS-1:0] ALU_ADD = 4'h2;
    localparam logic [ALUCTL_BITS-1:0] ALU_SUB = 4'h6;
    localparam logic [ALUCTL_BITS-1:0] ALU_SLT = 4'h7;

    typedef enum logic {
        BP_IDLE  = 1'b0,
        BP_CLEAR = 1'b1
    } bp_state_e;

endpackage

// File: rtl/bp_sat_counter.sv
// One predictor table entry: saturating up/down counter with synchronous load
// of the init value; exposes only the taken bit (counter MSB).
module bp_sat_counter #(
    parameter int unsigned CTR_BITS = 2,
    parameter int unsigned CTR_INIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    input  logic load,
    output logic taken
);

    localparam logic [CTR_BITS-1:0] INIT_VAL = CTR_BITS'(CTR_INIT);
    localparam logic [CTR_BITS-1:0] MAX_VAL  = '1;

    logic [CTR_BITS-1:0] ctr_q;
    logic [CTR_BITS-1:0] ctr_d;

    // Load wins over training; increments and decrements clamp at the ends.
    always_comb begin
        ctr_d = ctr_q;
        if (load) begin
            ctr_d = INIT_VAL;
        end else if (inc) begin
            if (ctr_q != MAX_VAL) ctr_d = ctr_q + CTR_BITS'(1);
        end else if (dec) begin
            if (ctr_q != '0) ctr_d = ctr_q - CTR_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ctr_q <= INIT_VAL;
        else        ctr_q <= ctr_d;
    end

    assign taken = ctr_q[CTR_BITS-1];

endmodule

// File: rtl/branch_predict_unit.sv
// Dynamic beq/bne predictor: PC-indexed saturating counter table, registered
// IF->ID prediction, EX resolution/training, mispredict stats and table clear.
module branch_predict_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned CTR_INIT   = 1,
    parameter int unsigned STAT_BITS  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_valid,
    input  logic                  if_stall,
    input  logic [PC_WIDTH-1:0]   if_pc,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  ex_branch,
    input  logic                  ex_branch_eq,
    input  logic                  ex_zero,
    input  logic                  ex_pred_taken,
    input  logic [INDEX_BITS-1:0] ex_index,
    output logic                  ex_taken,
    output logic                  mispredict,
    input  logic                  tbl_clear,
    output logic                  busy,
    output logic [STAT_BITS-1:0]  stat_branches,
    output logic [STAT_BITS-1:0]  stat_mispred
);

    localparam int unsigned           ENTRIES  = 2 ** INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(ENTRIES - 1);
    localparam logic [STAT_BITS-1:0]  STAT_MAX = '1;

    bp_state_e             state_q, state_d;
    logic [INDEX_BITS-1:0] clr_ptr_q, clr_ptr_d;
    logic                  pred_taken_q, pred_taken_d;
    logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;
    logic [STAT_BITS-1:0]  stat_branches_q, stat_branches_d;
    logic [STAT_BITS-1:0]  stat_mispred_q, stat_mispred_d;

    logic [ENTRIES-1:0]    entry_taken;
    logic [ENTRIES-1:0]    entry_inc;
    logic [ENTRIES-1:0]    entry_dec;
    logic [ENTRIES-1:0]    entry_load;
    logic [INDEX_BITS-1:0] if_idx;
    logic                  clearing;
    logic                  train_en;
    logic                  unused_pc_bits;

    assign if_idx         = if_pc[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{if_pc[PC_WIDTH-1:INDEX_BITS+2], if_pc[1:0]};
    assign clearing       = (state_q == BP_CLEAR);
    assign train_en       = ex_branch & ~clearing;

    assign ex_taken   = ex_branch & (ex_branch_eq ? ex_zero : ~ex_zero);
    assign mispredict = ex_branch & (ex_taken ^ ex_pred_taken);

    // Per-entry strobes: training hits one entry, clear walks clr_ptr.
    always_comb begin
        entry_inc             = '0;
        entry_dec             = '0;
        entry_load            = '0;
        entry_inc[ex_index]   = train_en & ex_taken;
        entry_dec[ex_index]   = train_en & ~ex_taken;
        entry_load[clr_ptr_q] = clearing;
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        bp_sat_counter #(
            .CTR_BITS (CTR_BITS),
            .CTR_INIT (CTR_INIT)
        ) u_ctr (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (entry_inc[g]),
            .dec   (entry_dec[g]),
            .load  (entry_load[g]),
            .taken (entry_taken[g])
        );
    end

    // Clear FSM: one entry per cycle, tbl_clear ignored once started.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            BP_IDLE: begin
                clr_ptr_d = '0;
                if (tbl_clear) state_d = BP_CLEAR;
            end
            BP_CLEAR: begin
                clr_ptr_d = clr_ptr_q + INDEX_BITS'(1);
                if (clr_ptr_q == LAST_IDX) begin
                    state_d   = BP_IDLE;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = BP_IDLE;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Prediction reads pre-update table state, so same-edge training is not bypassed.
    always_comb begin
        pred_taken_d = pred_taken_q;
        pred_index_d = pred_index_q;
        if (!if_stall) begin
            pred_index_d = if_idx;
            pred_taken_d = if_valid & entry_taken[if_idx] & ~clearing;
        end
    end

    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (train_en && stat_branches_q != STAT_MAX)
            stat_branches_d = stat_branches_q + STAT_BITS'(1);
        if (train_en && mispredict && stat_mispred_q != STAT_MAX)
            stat_mispred_d = stat_mispred_q + STAT_BITS'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= BP_IDLE;
            clr_ptr_q       <= '0;
            pred_taken_q    <= 1'b0;
            pred_index_q    <= '0;
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            state_q         <= state_d;
            clr_ptr_q       <= clr_ptr_d;
            pred_taken_q    <= pred_taken_d;
            pred_index_q    <= pred_index_d;
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign pred_taken    = pred_taken_q;
    assign pred_index    = pred_index_q;
    assign busy          = clearing;
    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: default instance plus a 4-bit stats
// instance sharing the same stimulus.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, if_stall, tbl_clear;
    logic [31:0] if_pc;
    logic        ex_branch, ex_branch_eq, ex_zero, ex_pred_taken;
    logic [5:0]  ex_index;

    logic        pred_taken, ex_taken, mispredict, busy;
    logic [5:0]  pred_index;
    logic [31:0] stat_branches, stat_mispred;

    logic        s_pred_taken, s_ex_taken, s_mispredict, s_busy;
    logic [5:0]  s_pred_index;
    logic [3:0]  s_stat_branches, s_stat_mispred;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk (clk), .rst_n (rst_n), .if_valid (if_valid), .if_stall (if_stall),
        .if_pc (if_pc), .pred_taken (pred_taken), .pred_index (pred_index),
        .ex_branch (ex_branch), .ex_branch_eq (ex_branch_eq), .ex_zero (ex_zero),
        .ex_pred_taken (ex_pred_taken), .ex_index (ex_index), .ex_taken (ex_taken),
        .mispredict (mispredict), .tbl_clear (tbl_clear), .busy (busy),
        .stat_branches (stat_branches), .stat_mispred (stat_mispred)
    );

    branch_predict_unit #(.STAT_BITS(4)) dut_s (
        .clk (clk), .rst_n (rst_n), .if_valid (if_valid), .if_stall (if_stall),
        .if_pc (if_pc), .pred_taken (s_pred_taken), .pred_index (s_pred_index),
        .ex_branch (ex_branch), .ex_branch_eq (ex_branch_eq), .ex_zero (ex_zero),
        .ex_pred_taken (ex_pred_taken), .ex_index (ex_index), .ex_taken (s_ex_taken),
        .mispredict (s_mispredict), .tbl_clear (tbl_clear), .busy (s_busy),
        .stat_branches (s_stat_branches), .stat_mispred (s_stat_mispred)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic br, input logic eq, input logic z,
                          input logic pt, input logic [5:0] idx);
        ex_branch     = br;
        ex_branch_eq  = eq;
        ex_zero       = z;
        ex_pred_taken = pt;
        ex_index      = idx;
    endtask

    // One resolved branch for one edge, then EX bubble.
    task automatic train(input logic eq, input logic z, input logic pt, input logic [5:0] idx);
        set_ex(1'b1, eq, z, pt, idx);
        tick();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
    endtask

    task automatic check_stats(input string tag, input int br, input int mp);
        check({tag, "_branches"}, stat_branches, 32'(br));
        check({tag, "_mispred"},  stat_mispred,  32'(mp));
    endtask

    initial begin
        rst_n = 1'b0; if_valid = 1'b1; if_stall = 1'b0; tbl_clear = 1'b0;
        if_pc = 32'h40;
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
        repeat (2) tick();
        check("rst_pred_taken", 32'(pred_taken), 32'd0);
        check("rst_pred_index", 32'(pred_index), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check_stats("rst", 0, 0);

        // 1: first prediction after reset
        rst_n = 1'b1;
        tick();
        check("t1_pred_index", 32'(pred_index), 32'h10);
        check("t1_pred_taken", 32'(pred_taken), 32'd0);
        check_stats("t1", 0, 0);

        // Resolution truth table
        set_ex(1'b1, 1'b0, 1'b0, 1'b0, 6'h00); #1;
        check("bne_z0_taken", 32'(ex_taken), 32'd1);
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 6'h00); #1;
        check("beq_z0_taken", 32'(ex_taken), 32'd0);
        check("beq_z0_misp",  32'(mispredict), 32'd1);
        set_ex(1'b0, 1'b1, 1'b1, 1'b0, 6'h00); #1;
        check("nobr_taken", 32'(ex_taken), 32'd0);
        check("nobr_misp",  32'(mispredict), 32'd0);
        tick();
        check_stats("nobr", 0, 0);

        // 2: train entry 0x10 upward, saturating at 3
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 6'h10); #1;
        check("t2_ex_taken", 32'(ex_taken), 32'd1);
        check("t2_misp",     32'(mispredict), 32'd1);
        tick();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
        check("t2_pred_old", 32'(pred_taken), 32'd0);
        tick();
        check("t2_pred_new", 32'(pred_taken), 32'd1);
        check_stats("t2", 1, 1);
        repeat (3) train(1'b1, 1'b1, 1'b1, 6'h10);
        tick();
        check("t2_sat_pred", 32'(pred_taken), 32'd1);
        check_stats("t2_sat", 4, 1);

        // 3: bne not-taken walks 3->2->1->0->0, then up 0->1->2
        set_ex(1'b1, 1'b0, 1'b1, 1'b1, 6'h10); #1;
        check("t3_ex_taken", 32'(ex_taken), 32'd0);
        check("t3_misp",     32'(mispredict), 32'd1);
        tick();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
        tick();
        check("t3_ctr2", 32'(pred_taken), 32'd1);
        train(1'b0, 1'b1, 1'b1, 6'h10);
        tick();
        check("t3_ctr1", 32'(pred_taken), 32'd0);
        repeat (2) train(1'b0, 1'b1, 1'b0, 6'h10);
        train(1'b1, 1'b1, 1'b0, 6'h10);
        tick();
        check("t3_no_underflow", 32'(pred_taken), 32'd0);
        train(1'b1, 1'b1, 1'b0, 6'h10);
        tick();
        check("t3_ctr2_again", 32'(pred_taken), 32'd1);
        check_stats("t3", 10, 5);

        // 4: same-edge train and read of entry 5
        if_pc = 32'h14;
        train(1'b1, 1'b1, 1'b0, 6'h05);
        check("t4_index",    32'(pred_index), 32'h05);
        check("t4_pred_old", 32'(pred_taken), 32'd0);
        tick();
        check("t4_pred_new", 32'(pred_taken), 32'd1);

        // if_stall holds prediction regs; training still happens
        if_pc = 32'h80; if_stall = 1'b1;
        train(1'b1, 1'b1, 1'b0, 6'h20);
        check("stall_index", 32'(pred_index), 32'h05);
        check("stall_pred",  32'(pred_taken), 32'd1);
        if_stall = 1'b0;
        tick();
        check("stall_released", 32'(pred_taken), 32'd1);
        check_stats("t4", 12, 7);

        // 6: 19 more mispredicts -> 4-bit stats saturate
        repeat (19) train(1'b1, 1'b1, 1'b0, 6'h21);
        check("t6_s_branches", 32'(s_stat_branches), 32'hF);
        check("t6_s_mispred",  32'(s_stat_mispred),  32'hF);
        check_stats("t6", 31, 26);
        tick();
        check("t6_s_hold", 32'(s_stat_branches), 32'hF);
        check_stats("t6_idle", 31, 26);

        // 5: table clear; entry 0x10 (=2) would predict taken
        if_pc = 32'h40;
        tick();
        check("t5_pre_pred", 32'(pred_taken), 32'd1);
        tbl_clear = 1'b1;
        tick();
        tbl_clear = 1'b0;
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 6'h10);
        check("t5_busy_0", 32'(busy), 32'd1);
        for (int k = 1; k < 64; k++) begin
            tbl_clear = (k == 30);
            tick();
            check($sformatf("t5_busy_%0d", k), 32'(busy), 32'd1);
            check($sformatf("t5_pred_%0d", k), 32'(pred_taken), 32'd0);
        end
        tbl_clear = 1'b0;
        tick();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
        check("t5_busy_done", 32'(busy), 32'd0);
        check_stats("t5", 31, 26);
        tick();
        check("t5_clr_0x10", 32'(pred_taken), 32'd0);
        if_pc = 32'h14; tick();
        check("t5_clr_0x05", 32'(pred_taken), 32'd0);
        if_pc = 32'h84; tick();
        check("t5_clr_0x21", 32'(pred_taken), 32'd0);
        if_pc = 32'h40;
        train(1'b1, 1'b1, 1'b0, 6'h10);
        tick();
        check("t5_init_is_1", 32'(pred_taken), 32'd1);

        // 5b: reset 20 cycles into a clear aborts it
        tbl_clear = 1'b1;
        tick();
        tbl_clear = 1'b0;
        repeat (20) tick();
        check("t5b_busy", 32'(busy), 32'd1);
        rst_n = 1'b0; #1;
        check("t5b_abort_busy", 32'(busy), 32'd0);
        check_stats("t5b", 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t5b_busy_after", 32'(busy), 32'd0);
        check("t5b_pred_after", 32'(pred_taken), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
